usb_ep2_stream_arbiter: RTL

Shares USB bulk endpoint #2 (IN direction, 8-bit AXI4-Stream) between NUM_SRC packet sources, such as the visibility readout and the raw-sample capture stream.
- Arbitration is round-robin and only happens at packet boundaries.
- Each forwarded packet is prefixed with a one-byte source-ID header.
- Over-long packets are truncated by a length watchdog.
- Sits in the USB clock domain, between the data producers and the ULPI wrapper's EP2 slave port.

---
 rtl/usb_arb_pkg.sv | 21 ++
 rtl/usb_ep2_stream_arbiter_rr_pick.sv | 36 +++
 rtl/usb_ep2_stream_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/usb_arb_pkg.sv
// Shared types and constants for the EP2 stream arbiter.
package usb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam logic [3:0]  HDR_TAG_DEF = 4'hA;
    localparam int unsigned PKT_CNT_W   = 16;
    localparam int unsigned TRUNC_CNT_W = 8;
    localparam int unsigned BEAT_CNT_W  = 16;

    // Width of a source index; a single source still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/usb_ep2_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Smallest rotational distance from ptr_i+1 wins.
    always_comb begin
        int unsigned d;
        int unsigned best_d;
        best_d = N;
        d      = 0;
        idx_o  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (req_i[k]) begin
                d = (k + N - 32'(ptr_i) - 1) % N;
                if (d < best_d) begin
                    best_d = d;
                    idx_o  = IW'(k);
                end
            end
        end
        any_o = (best_d < N);
        gnt_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            gnt_o[k] = any_o && (idx_o == IW'(k));
        end
    end

endmodule

// File: rtl/usb_ep2_stream_arbiter.sv
// Packet-boundary round-robin arbiter for USB EP2 IN with source-ID header
// and length watchdog.
module usb_ep2_stream_arbiter
    import usb_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned MAX_LEN = 512,
    parameter logic [3:0]  HDR_TAG = HDR_TAG_DEF
) (
    input  logic                   clock,
    input  logic                   areset_n,
    input  logic                   enable_i,
    input  logic [NUM_SRC-1:0]     s_tvalid,
    output logic [NUM_SRC-1:0]     s_tready,
    input  logic [NUM_SRC-1:0]     s_tlast,
    input  logic [NUM_SRC-1:0]     s_tkeep,
    input  logic [8*NUM_SRC-1:0]   s_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   m_tlast,
    output logic                   m_tkeep,
    output logic [7:0]             m_tdata,
    output logic [NUM_SRC-1:0]     grant_o,
    output logic [PKT_CNT_W-1:0]   pkt_count_o,
    output logic [TRUNC_CNT_W-1:0] trunc_count_o
);

    localparam int unsigned           IW        = idx_width(NUM_SRC);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_LEN - 1);
    localparam logic [IW-1:0]         PTR_RST   = IW'(NUM_SRC - 1);

    arb_state_t             state_q, state_d;
    logic [NUM_SRC-1:0]     grant_q, grant_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [BEAT_CNT_W-1:0]  beat_q, beat_d;
    logic [PKT_CNT_W-1:0]   pkt_q, pkt_d;
    logic [TRUNC_CNT_W-1:0] trunc_q, trunc_d;

    logic [NUM_SRC-1:0] pick_gnt;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;

    logic       src_valid;
    logic       src_last;
    logic       src_keep;
    logic [7:0] src_data;
    logic       at_limit;

    rr_pick #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr_pick (
        .req_i (s_tvalid),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign src_valid = s_tvalid[idx_q];
    assign src_last  = s_tlast[idx_q];
    assign src_keep  = s_tkeep[idx_q];
    assign src_data  = s_tdata[{idx_q, 3'b000} +: 8];
    assign at_limit  = (beat_q == LAST_BEAT);

    // State and bookkeeping registers.
    always_ff @(posedge clock or negedge areset_n) begin
        if (!areset_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
            beat_q  <= '0;
            pkt_q   <= '0;
            trunc_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
            pkt_q   <= pkt_d;
            trunc_q <= trunc_d;
        end
    end

    // Next-state: grant in IDLE, count beats in DATA, discard tail in DRAIN.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        pkt_d   = pkt_q;
        trunc_d = trunc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (enable_i && pick_any) begin
                    state_d = ST_HEAD;
                    grant_d = pick_gnt;
                    idx_d   = pick_idx;
                    ptr_d   = pick_idx;
                end
            end
            ST_HEAD: begin
                if (m_tready) begin
                    state_d = ST_DATA;
                    beat_d  = '0;
                end
            end
            ST_DATA: begin
                if (src_valid && m_tready) begin
                    beat_d = beat_q + 1'b1;
                    if (src_last) begin
                        pkt_d   = pkt_q + 1'b1;
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else if (at_limit) begin
                        pkt_d   = pkt_q + 1'b1;
                        if (trunc_q != '1) begin
                            trunc_d = trunc_q + 1'b1;
                        end
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (src_valid && src_last) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs: header byte, then combinational pass-through of the owner.
    always_comb begin
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tkeep  = 1'b0;
        m_tdata  = '0;
        s_tready = '0;
        unique case (state_q)
            ST_HEAD: begin
                m_tvalid = 1'b1;
                m_tkeep  = 1'b1;
                m_tdata  = {HDR_TAG, 4'(idx_q)};
            end
            ST_DATA: begin
                m_tvalid        = src_valid;
                m_tkeep         = src_keep;
                m_tdata         = src_data;
                m_tlast         = src_last | at_limit;
                s_tready[idx_q] = m_tready;
            end
            ST_DRAIN: begin
                s_tready[idx_q] = 1'b1;
            end
            default: ;
        endcase
    end

    assign grant_o       = grant_q;
    assign pkt_count_o   = pkt_q;
    assign trunc_count_o = trunc_q;

endmodule
